// File: rtl/noun_loader.sv
// Loads a (hed,tel) noun image from a valid/ready word stream into the NPU program memories.
// Optional trailing checksum word is enabled by defining NOUN_LOADER_CHECKSUM_EN.
module noun_loader #(
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [31:0]       in_word,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_hed,
    output logic [31:0]       mem_tel,
    output logic              busy,
    output logic              done,
    output logic              npu_go,
    output logic              error,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   cell_count
);

    localparam logic [31:0]     DEPTH = 32'(2 ** ADDR_W);
    localparam logic [ADDR_W:0] ONE   = (ADDR_W + 1)'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_HED,
        S_TEL,
        S_DONE,
        S_ERR,
`ifdef NOUN_LOADER_CHECKSUM_EN
        S_CSUM
`else
        S_WRAP
`endif
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        err_code_q, err_code_d;
    logic [ADDR_W:0]   cell_count_q;
    logic [ADDR_W-1:0] idx_q;
    logic [31:0]       hed_q;
    logic              done_d1_q;
    logic              wr_cell;
    logic              xfer;
    logic              last_cell;
    logic              hdr_bad;
`ifdef NOUN_LOADER_CHECKSUM_EN
    logic [31:0]       csum_q;
`endif

    // Nil is legal only as a tel word; pointers must land inside the loaded image.
    function automatic logic tag_ok(input logic [31:0] w, input logic is_tel,
                                    input logic [ADDR_W:0] n);
        logic ok;
        ok = 1'b0;
        if (w == 32'hFFFF_FFFF) begin
            ok = is_tel;
        end else begin
            case (w[31:29])
                3'b000, 3'b001, 3'b010, 3'b011: ok = 1'b1;
                3'b101:                         ok = 1'b1;
                3'b111: ok = (w[28:ADDR_W] == '0) && ({1'b0, w[ADDR_W-1:0]} < n);
                default:                        ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

    // in_ready depends on state only, so the upstream may hold in_valid on it without a loop.
`ifdef NOUN_LOADER_CHECKSUM_EN
    assign in_ready = (state_q == S_HDR) || (state_q == S_HED) ||
                      (state_q == S_TEL) || (state_q == S_CSUM);
`else
    assign in_ready = (state_q == S_HDR) || (state_q == S_HED) || (state_q == S_TEL);
`endif

    assign xfer       = in_valid && in_ready;
    assign hdr_bad    = (in_word == '0) || (in_word > DEPTH);
    assign last_cell  = ({1'b0, idx_q} == (cell_count_q - ONE));
    assign busy       = in_ready || mem_we;
    assign done       = (state_q == S_DONE);
    assign error      = (state_q == S_ERR);
    assign err_code   = err_code_q;
    assign cell_count = cell_count_q;

    // NOTE: every variable gets its default before the case, otherwise paths that
    // skip an assignment infer a latch.
    always_comb begin
        state_d    = state_q;
        err_code_d = err_code_q;
        wr_cell    = 1'b0;
        case (state_q)
            S_IDLE: if (start) state_d = S_HDR;
            S_HDR: begin
                if (xfer) begin
                    if (hdr_bad) begin
                        state_d    = S_ERR;
                        err_code_d = 2'd1;
                    end else begin
                        state_d = S_HED;
                    end
                end
            end
            S_HED: begin
                if (xfer) begin
                    if (!tag_ok(in_word, 1'b0, cell_count_q)) begin
                        state_d    = S_ERR;
                        err_code_d = 2'd2;
                    end else begin
                        state_d = S_TEL;
                    end
                end
            end
            S_TEL: begin
                if (xfer) begin
                    if (!tag_ok(in_word, 1'b1, cell_count_q)) begin
                        state_d    = S_ERR;
                        err_code_d = 2'd2;
                    end else begin
                        wr_cell = 1'b1;
`ifdef NOUN_LOADER_CHECKSUM_EN
                        state_d = last_cell ? S_CSUM : S_HED;
`else
                        state_d = last_cell ? S_WRAP : S_HED;
`endif
                    end
                end
            end
`ifdef NOUN_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (xfer) begin
                    if (in_word == csum_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d    = S_ERR;
                        err_code_d = 2'd3;
                    end
                end
            end
`else
            // Trailing cycle that carries the final cell's write strobe.
            S_WRAP: state_d = S_DONE;
`endif
            S_DONE, S_ERR: begin
                if (start) begin
                    state_d    = S_HDR;
                    err_code_d = 2'd0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            err_code_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            err_code_q <= err_code_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cell_count_q <= '0;
            idx_q        <= '0;
            hed_q        <= '0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_hed      <= '0;
            mem_tel      <= '0;
            done_d1_q    <= 1'b0;
            npu_go       <= 1'b0;
`ifdef NOUN_LOADER_CHECKSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            mem_we    <= wr_cell;
            done_d1_q <= (state_q == S_DONE);
            npu_go    <= (state_q == S_DONE) && !done_d1_q;
            if (state_q == S_HDR && xfer && !hdr_bad) begin
                cell_count_q <= in_word[ADDR_W:0];
                idx_q        <= '0;
`ifdef NOUN_LOADER_CHECKSUM_EN
                csum_q       <= in_word;
`endif
            end
            if (state_q == S_HED && xfer) begin
                hed_q <= in_word;
`ifdef NOUN_LOADER_CHECKSUM_EN
                csum_q <= csum_q ^ in_word;
`endif
            end
            if (wr_cell) begin
                mem_addr <= idx_q;
                mem_hed  <= hed_q;
                mem_tel  <= in_word;
                idx_q    <= idx_q + 1'b1;
`ifdef NOUN_LOADER_CHECKSUM_EN
                csum_q   <= csum_q ^ in_word;
`endif
            end
        end
    end

endmodule

// File: tb/tb_noun_loader.sv
// Scoreboard bench for noun_loader: expected memory writes are queued when an image is
// driven and popped as mem_we pulses appear.
module tb_noun_loader;

    localparam int ADDR_W = 3;

    logic              clk;
    logic              reset;
    logic              start;
    logic              in_valid;
    logic [31:0]       in_word;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_hed;
    logic [31:0]       mem_tel;
    logic              busy;
    logic              done;
    logic              npu_go;
    logic              error;
    logic [1:0]        err_code;
    logic [ADDR_W:0]   cell_count;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       hed;
        logic [31:0]       tel;
    } wr_t;

    wr_t         sb[$];
    wr_t         exp_wr;
    int          n_checks = 0;
    int          n_pass   = 0;
    int          go_count = 0;
    logic        done_p   = 1'b0;
    logic        done_p2  = 1'b0;
    logic        we_p     = 1'b0;
    logic [31:0] img_hed[8];
    logic [31:0] img_tel[8];

    noun_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_word    (in_word),
        .in_ready   (in_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_hed    (mem_hed),
        .mem_tel    (mem_tel),
        .busy       (busy),
        .done       (done),
        .npu_go     (npu_go),
        .error      (error),
        .err_code   (err_code),
        .cell_count (cell_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Monitor: pop the scoreboard on each write, and track the done -> npu_go relation.
    always @(negedge clk) begin
        if (reset) begin
            if (mem_we) begin
                if (sb.size() == 0) begin
                    check("unexpected_we", 64'(mem_we), 64'd0);
                end else begin
                    exp_wr = sb.pop_front();
                    check("wr_addr", 64'(mem_addr), 64'(exp_wr.addr));
                    check("wr_hed",  64'(mem_hed),  64'(exp_wr.hed));
                    check("wr_tel",  64'(mem_tel),  64'(exp_wr.tel));
                end
            end
            if (npu_go || (done && done_p && !done_p2))
                check("npu_go_timing", 64'(npu_go), 64'(done && done_p && !done_p2));
            if (npu_go) go_count <= go_count + 1;
`ifndef NOUN_LOADER_CHECKSUM_EN
            if (done && !done_p) check("done_after_we", 64'(we_p), 64'd1);
`endif
        end
        done_p2 <= done_p;
        done_p  <= done;
        we_p    <= mem_we;
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Presents one word; in_ready is a function of state, so it is stable from #1 to the edge.
    task automatic send_word(input logic [31:0] w, input bit gappy);
        int n;
        if (gappy) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_word  = w;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            check("ready_timeout", 64'(in_ready), 64'd1);
        end else begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic run_load(input string tag, input logic [31:0] n_hdr, input int n_words,
                            input int n_good, input bit gappy, input bit csum_flip,
                            input logic exp_done, input logic [1:0] exp_code);
        logic [31:0] csum;
        logic [31:0] w;
        int          go0;
        go0 = go_count;
        for (int i = 0; i < n_good; i++) sb.push_back({ADDR_W'(i), img_hed[i], img_tel[i]});
        pulse_start();
        send_word(n_hdr, gappy);
        csum = n_hdr;
        for (int k = 0; k < n_words; k++) begin
            w = (k % 2 == 0) ? img_hed[k / 2] : img_tel[k / 2];
            send_word(w, gappy);
            csum = csum ^ w;
        end
`ifdef NOUN_LOADER_CHECKSUM_EN
        if (n_hdr != 0 && n_words == 2 * int'(n_hdr))
            send_word(csum ^ {31'd0, csum_flip}, gappy);
`else
        if (csum_flip) csum = ~csum;
`endif
        repeat (5) @(posedge clk);
        #1;
        check({tag, "_done"},     64'(done),     64'(exp_done));
        check({tag, "_error"},    64'(error),    64'(!exp_done));
        check({tag, "_err_code"}, 64'(err_code), 64'(exp_code));
        check({tag, "_busy"},     64'(busy),     64'd0);
        check({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
        check({tag, "_go_count"}, 64'(go_count - go0), 64'(exp_done));
        if (exp_done) check({tag, "_cell_count"}, 64'(cell_count), 64'(n_hdr));
    endtask

    task automatic load_test1_image();
        img_hed[0] = 32'hE000_0001; img_tel[0] = 32'hFFFF_FFFF;
        img_hed[1] = 32'hE000_0002; img_tel[1] = 32'hE000_0003;
        img_hed[2] = 32'h0000_0004; img_tel[2] = 32'h0000_0005;
        img_hed[3] = 32'h0000_0006; img_tel[3] = 32'hE000_0004;
        img_hed[4] = 32'h0000_000E; img_tel[4] = 32'h0000_000F;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"},   64'(in_ready),   64'd0);
        check({tag, "_mem_we"},     64'(mem_we),     64'd0);
        check({tag, "_mem_addr"},   64'(mem_addr),   64'd0);
        check({tag, "_mem_hed"},    64'(mem_hed),    64'd0);
        check({tag, "_mem_tel"},    64'(mem_tel),    64'd0);
        check({tag, "_busy"},       64'(busy),       64'd0);
        check({tag, "_done"},       64'(done),       64'd0);
        check({tag, "_npu_go"},     64'(npu_go),     64'd0);
        check({tag, "_error"},      64'(error),      64'd0);
        check({tag, "_err_code"},   64'(err_code),   64'd0);
        check({tag, "_cell_count"}, 64'(cell_count), 64'd0);
    endtask

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_word  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b1;
        @(posedge clk); #1;

        // 1: clean five-cell load; 2: same image with in_valid toggling every cycle.
        load_test1_image();
        run_load("t1", 32'd5, 10, 5, 1'b0, 1'b0, 1'b1, 2'd0);
        run_load("t2", 32'd5, 10, 5, 1'b1, 1'b0, 1'b1, 2'd0);

        // 3: header counts outside 1..8.
        run_load("t3_n9", 32'd9, 0, 0, 1'b0, 1'b0, 1'b0, 2'd1);
        run_load("t3_n0", 32'd0, 0, 0, 1'b0, 1'b0, 1'b0, 2'd1);

        // 4: pointer E0000002 is out of range for N=2; only cell 0 lands.
        img_hed[0] = 32'hE000_0001; img_tel[0] = 32'hFFFF_FFFF;
        img_hed[1] = 32'hE000_0002; img_tel[1] = 32'h0000_0000;
        run_load("t4", 32'd2, 3, 1, 1'b0, 1'b0, 1'b0, 2'd2);

        // Nil in a hed slot is rejected.
        img_hed[0] = 32'hFFFF_FFFF;
        run_load("t4_nil_hed", 32'd1, 1, 0, 1'b0, 1'b0, 1'b0, 2'd2);

        // 5: reset while cell 2 of a five-cell load is in flight, then a full reload.
        load_test1_image();
        sb.push_back({ADDR_W'(0), img_hed[0], img_tel[0]});
        sb.push_back({ADDR_W'(1), img_hed[1], img_tel[1]});
        pulse_start();
        send_word(32'd5, 1'b0);
        send_word(img_hed[0], 1'b0);
        send_word(img_tel[0], 1'b0);
        send_word(img_hed[1], 1'b0);
        send_word(img_tel[1], 1'b0);
        send_word(img_hed[2], 1'b0);
        reset = 1'b0;
        #1;
        check_all_zero("t5_abort");
        check("t5_sb_empty", 64'(sb.size()), 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        run_load("t5_reload", 32'd5, 10, 5, 1'b0, 1'b0, 1'b1, 2'd0);

`ifdef NOUN_LOADER_CHECKSUM_EN
        // 6: checksum with bit 0 flipped; cells stay written, error code 3.
        run_load("t6_bad_csum", 32'd5, 10, 5, 1'b0, 1'b1, 1'b0, 2'd3);
        run_load("t6_good_csum", 32'd5, 10, 5, 1'b0, 1'b0, 1'b1, 2'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
